// File: rtl/count_sequencer.sv
// Measurement sequencer: clears/enables the pulse counter and gates prebuffer writes over N full periods.
// Optional build macro SEQ_OVERRUN_ABORT_EN: a FIFO overrun also aborts the running sequence.
module count_sequencer #(
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int PER_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_chan,
  input  logic             cfg_alt,
  input  logic [PER_W-1:0] cfg_periods,
  input  logic             rising_edge,
  input  logic             fifo_wr_en,
  input  logic             fifo_full,
  output logic             count_mode,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             fifo_wr_gate,
  output logic             busy,
  output logic             chan_done,
  output logic             seq_done,
  output logic             timeout,
  output logic             overrun
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] periods_q;
  logic             alt_q;
  logic             on_second;
  logic             overrun_hit;
  logic             ovr_abort;

  // A zero period request still measures one full period.
  function automatic logic [PER_W-1:0] eff_periods(input logic [PER_W-1:0] p);
    return (p == '0) ? PER_W'(1) : p;
  endfunction

  assign overrun_hit = fifo_wr_en & fifo_wr_gate & fifo_full;

`ifdef SEQ_OVERRUN_ABORT_EN
  assign ovr_abort = overrun_hit;
`else
  assign ovr_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      clr_cnt      <= '0;
      to_cnt       <= '0;
      per_cnt      <= '0;
      periods_q    <= PER_W'(1);
      alt_q        <= 1'b0;
      on_second    <= 1'b0;
      count_mode   <= 1'b0;
      cnt_enable   <= 1'b0;
      cnt_clear    <= 1'b0;
      fifo_wr_gate <= 1'b0;
      busy         <= 1'b0;
      chan_done    <= 1'b0;
      seq_done     <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      chan_done    <= 1'b0;
      seq_done     <= 1'b0;
      // Gate lags MEASURE by one clock to line up with the prebuffer write latency.
      fifo_wr_gate <= (state == S_MEASURE);
      if (overrun_hit) overrun <= 1'b1;

      if (stop || ovr_abort) begin
        state        <= S_IDLE;
        cnt_enable   <= 1'b0;
        cnt_clear    <= 1'b0;
        fifo_wr_gate <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_CLEAR;
              count_mode <= cfg_chan;
              alt_q      <= cfg_alt;
              periods_q  <= eff_periods(cfg_periods);
              on_second  <= 1'b0;
              timeout    <= 1'b0;
              overrun    <= 1'b0;
              clr_cnt    <= '0;
              cnt_clear  <= 1'b1;
              cnt_enable <= 1'b0;
              busy       <= 1'b1;
            end
          end

          S_CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
              state      <= S_ARM;
              cnt_clear  <= 1'b0;
              cnt_enable <= 1'b1;
              to_cnt     <= '0;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end

          S_ARM: begin
            // The aligning edge only opens the window; its partial period is dropped.
            if (rising_edge) begin
              state   <= S_MEASURE;
              per_cnt <= '0;
              to_cnt  <= '0;
            end else if (to_cnt == TO_LAST) begin
              state      <= S_IDLE;
              timeout    <= 1'b1;
              cnt_enable <= 1'b0;
              busy       <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          S_MEASURE: begin
            if (rising_edge) begin
              to_cnt <= '0;
              if (per_cnt + PER_W'(1) == periods_q) begin
                state     <= S_DONE;
                chan_done <= 1'b1;
                seq_done  <= !(alt_q && !on_second);
              end else begin
                per_cnt <= per_cnt + PER_W'(1);
              end
            end else if (to_cnt == TO_LAST) begin
              state      <= S_IDLE;
              timeout    <= 1'b1;
              cnt_enable <= 1'b0;
              busy       <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          S_DONE: begin
            if (alt_q && !on_second) begin
              state      <= S_CLEAR;
              on_second  <= 1'b1;
              count_mode <= ~count_mode;
              clr_cnt    <= '0;
              cnt_clear  <= 1'b1;
              cnt_enable <= 1'b0;
            end else begin
              state      <= S_IDLE;
              cnt_enable <= 1'b0;
              busy       <= 1'b0;
            end
          end

          default: begin
            state      <= S_IDLE;
            cnt_enable <= 1'b0;
            cnt_clear  <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
